// File: rtl/pipelined_type_decoder_if.sv
// Handshake and result bus for the pipelined RV32I type decoder stage.
// The master side belongs to fetch and the downstream consumer. The slave side belongs to the decoder.
interface pipelined_type_decoder_if #(
    parameter int unsigned INSTR_W = 32
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr_i;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] instr_o;
    logic [11:0]        class_o;
    logic [4:0]         rd_o;
    logic [4:0]         rs1_o;
    logic [4:0]         rs2_o;
    logic [2:0]         funct3_o;
    logic               stall_o;

    modport master (
        output flush, in_valid, instr_i, out_ready,
        input  in_ready, out_valid, instr_o, class_o, rd_o, rs1_o, rs2_o, funct3_o, stall_o
    );

    modport slave (
        input  flush, in_valid, instr_i, out_ready,
        output in_ready, out_valid, instr_o, class_o, rd_o, rs1_o, rs2_o, funct3_o, stall_o
    );
endinterface

// File: rtl/pipelined_type_decoder.sv
// One pipeline stage that classifies RV32I instructions into a one-hot class and extracts register fields.
// It also inserts bubbles on load-use hazards against the previously accepted instruction.
module pipelined_type_decoder #(
    parameter int unsigned INSTR_W      = 32,
    parameter int unsigned STALL_CYCLES = 1,
    parameter bit          EN_SYSTEM    = 1'b1
) (
    input logic                    clk,
    input logic                    rst,
    pipelined_type_decoder_if.slave bus
);

    typedef enum logic {
        RUN,
        STALL
    } state_t;

    localparam int unsigned C_R      = 0;
    localparam int unsigned C_I      = 1;
    localparam int unsigned C_LOAD   = 2;
    localparam int unsigned C_STORE  = 3;
    localparam int unsigned C_BRANCH = 4;
    localparam int unsigned C_JAL    = 5;
    localparam int unsigned C_JALR   = 6;
    localparam int unsigned C_LUI    = 7;
    localparam int unsigned C_AUIPC  = 8;
    localparam int unsigned C_FENCE  = 9;
    localparam int unsigned C_SYSTEM = 10;
    localparam int unsigned C_ILL    = 11;

    localparam logic [2:0] STALL_INIT = 3'(STALL_CYCLES);

    state_t             state;
    logic [2:0]         cnt;
    logic               last_load;
    logic [4:0]         last_rd;

    logic               out_valid;
    logic [INSTR_W-1:0] instr_q;
    logic [11:0]        class_q;
    logic [4:0]         rd_q;
    logic [4:0]         rs1_q;
    logic [4:0]         rs2_q;
    logic [2:0]         funct3_q;

    logic [6:0]         opcode;
    logic [11:0]        cls;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               hazard;
    logic               can_advance;
    logic               in_ready;
    logic               accept;

    assign opcode = bus.instr_i[6:0];
    assign rd     = bus.instr_i[11:7];
    assign funct3 = bus.instr_i[14:12];
    assign rs1    = bus.instr_i[19:15];
    assign rs2    = bus.instr_i[24:20];

    always_comb begin
        cls = '0;
        if (bus.instr_i[1:0] != 2'b11) begin
            cls[C_ILL] = 1'b1;
        end else begin
            case (opcode)
                7'b0110011: cls[C_R]      = 1'b1;
                7'b0010011: cls[C_I]      = 1'b1;
                7'b0000011: cls[C_LOAD]   = 1'b1;
                7'b0100011: cls[C_STORE]  = 1'b1;
                7'b1100011: cls[C_BRANCH] = 1'b1;
                7'b1101111: cls[C_JAL]    = 1'b1;
                7'b1100111: cls[C_JALR]   = 1'b1;
                7'b0110111: cls[C_LUI]    = 1'b1;
                7'b0010111: cls[C_AUIPC]  = 1'b1;
                7'b0001111: begin
                    if (EN_SYSTEM) cls[C_FENCE] = 1'b1;
                    else           cls[C_ILL]   = 1'b1;
                end
                7'b1110011: begin
                    if (EN_SYSTEM) cls[C_SYSTEM] = 1'b1;
                    else           cls[C_ILL]    = 1'b1;
                end
                default:    cls[C_ILL]    = 1'b1;
            endcase
        end
    end

    always_comb begin
        uses_rs1 = cls[C_R] | cls[C_STORE] | cls[C_BRANCH] |
                   cls[C_I] | cls[C_LOAD]  | cls[C_JALR];
        uses_rs2 = cls[C_R] | cls[C_STORE] | cls[C_BRANCH];
        hazard   = bus.in_valid & last_load & (last_rd != 5'd0) &
                   ((uses_rs1 & (rs1 == last_rd)) | (uses_rs2 & (rs2 == last_rd)));
    end

    assign can_advance = !out_valid | bus.out_ready;
    assign in_ready    = !bus.flush & (state == RUN) & !hazard & can_advance;
    assign accept      = bus.in_valid & in_ready;

    // The bubble count includes the cycle in which the held instruction is finally accepted.
    // For that reason the FSM returns to RUN once the counter is about to reach 1, and a single-bubble stall never enters STALL at all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            last_load <= 1'b0;
            last_rd   <= '0;
            out_valid <= 1'b0;
            instr_q   <= '0;
            class_q   <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            funct3_q  <= '0;
        end else if (bus.flush) begin
            state     <= RUN;
            cnt       <= '0;
            last_load <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                instr_q   <= bus.instr_i;
                class_q   <= cls;
                rd_q      <= rd;
                rs1_q     <= rs1;
                rs2_q     <= rs2;
                funct3_q  <= funct3;
                last_load <= cls[C_LOAD];
                last_rd   <= rd;
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                RUN: begin
                    if (hazard && can_advance) begin
                        cnt <= STALL_INIT;
                        if (STALL_CYCLES <= 1) begin
                            last_load <= 1'b0;
                        end else begin
                            state <= STALL;
                        end
                    end
                end
                STALL: begin
                    cnt <= cnt - 3'd1;
                    if (cnt <= 3'd2) begin
                        state     <= RUN;
                        last_load <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.instr_o   = instr_q;
    assign bus.class_o   = class_q;
    assign bus.rd_o      = rd_q;
    assign bus.rs1_o     = rs1_q;
    assign bus.rs2_o     = rs2_q;
    assign bus.funct3_o  = funct3_q;
    assign bus.stall_o   = (state == STALL) | hazard;

endmodule

// File: tb/tb_pipelined_type_decoder.sv
// Self-checking bench for pipelined_type_decoder. Two instances are used: A has one stall bubble with system decode enabled, and B has three stall bubbles with system decode disabled.
// Results are checked by a scoreboard and a vector table, with hand sequences for stall, hold, flush and reset.
module tb_pipelined_type_decoder;

    typedef struct packed {
        logic [31:0] instr;
        logic [11:0] cls;
    } exp_t;

    typedef struct {
        logic        sel;
        logic [31:0] instr;
        logic [11:0] cls;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_ready;
    logic        flush;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t cur_exp;
    exp_t e;
    exp_t sb[$];
    int   out_cyc[$];

    always #5 clk = ~clk;

    pipelined_type_decoder_if #(.INSTR_W(32)) ifa ();
    pipelined_type_decoder_if #(.INSTR_W(32)) ifb ();

    assign ifa.in_valid  = in_valid & !sel;
    assign ifb.in_valid  = in_valid & sel;
    assign ifa.flush     = flush & !sel;
    assign ifb.flush     = flush & sel;
    assign ifa.instr_i   = instr;
    assign ifb.instr_i   = instr;
    assign ifa.out_ready = out_ready;
    assign ifb.out_ready = out_ready;

    pipelined_type_decoder #(.INSTR_W(32), .STALL_CYCLES(1), .EN_SYSTEM(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    pipelined_type_decoder #(.INSTR_W(32), .STALL_CYCLES(3), .EN_SYSTEM(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    logic        o_in_ready, o_out_valid, o_stall;
    logic [31:0] o_instr;
    logic [11:0] o_class;
    logic [4:0]  o_rd, o_rs1, o_rs2;
    logic [2:0]  o_f3;

    assign o_in_ready  = sel ? ifb.in_ready  : ifa.in_ready;
    assign o_out_valid = sel ? ifb.out_valid : ifa.out_valid;
    assign o_stall     = sel ? ifb.stall_o   : ifa.stall_o;
    assign o_instr     = sel ? ifb.instr_o   : ifa.instr_o;
    assign o_class     = sel ? ifb.class_o   : ifa.class_o;
    assign o_rd        = sel ? ifb.rd_o      : ifa.rd_o;
    assign o_rs1       = sel ? ifb.rs1_o     : ifa.rs1_o;
    assign o_rs2       = sel ? ifb.rs2_o     : ifa.rs2_o;
    assign o_f3        = sel ? ifb.funct3_o  : ifa.funct3_o;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            cyc++;
            if (o_out_valid && out_ready) begin
                out_cyc.push_back(cyc);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got instr %h class %h, required no output", o_instr, o_class);
                end else begin
                    e = sb.pop_front();
                    if ({o_instr, o_class, o_rd, o_rs1, o_rs2, o_f3} !==
                        {e.instr, e.cls, e.instr[11:7], e.instr[19:15], e.instr[24:20], e.instr[14:12]}) begin
                        errors++;
                        $display("FAIL sb_result: got instr %h class %h rd %0d rs1 %0d rs2 %0d f3 %0d, required instr %h class %h",
                                 o_instr, o_class, o_rd, o_rs1, o_rs2, o_f3, e.instr, e.cls);
                    end
                end
            end
            if (in_valid && o_in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic present(input logic [31:0] w, input logic [11:0] c);
        cur_exp  = '{instr: w, cls: c};
        instr    = w;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [31:0] w, input logic [11:0] c);
        bit ok;
        ok = 1'b0;
        present(w, c);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (o_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: instr %h never accepted, required acceptance within 40 cycles", w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam int NV = 19;
    vec_t vecs[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 32'h002081B3, 12'h001};
        vecs[1]  = '{1'b0, 32'h00100093, 12'h002};
        vecs[2]  = '{1'b0, 32'h0000A283, 12'h004};
        vecs[3]  = '{1'b0, 32'h0020A223, 12'h008};
        vecs[4]  = '{1'b0, 32'h00208063, 12'h010};
        vecs[5]  = '{1'b0, 32'h000000EF, 12'h020};
        vecs[6]  = '{1'b0, 32'h00008067, 12'h040};
        vecs[7]  = '{1'b0, 32'h000012B7, 12'h080};
        vecs[8]  = '{1'b0, 32'h00000297, 12'h100};
        vecs[9]  = '{1'b0, 32'h0000000F, 12'h200};
        vecs[10] = '{1'b0, 32'h00000073, 12'h400};
        vecs[11] = '{1'b0, 32'h0000007F, 12'h800};
        vecs[12] = '{1'b0, 32'h00000000, 12'h800};
        vecs[13] = '{1'b0, 32'h00000057, 12'h800};
        vecs[14] = '{1'b1, 32'h002081B3, 12'h001};
        vecs[15] = '{1'b1, 32'h00000073, 12'h800};
        vecs[16] = '{1'b1, 32'h0000000F, 12'h800};
        vecs[17] = '{1'b1, 32'h000000EF, 12'h020};
        vecs[18] = '{1'b1, 32'h0000007F, 12'h800};

        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b1; flush = 1'b0;
        cur_exp = '0;
        #2;
        chk("reset_out_valid", 32'(o_out_valid), 32'd0);
        chk("reset_class", 32'(o_class), 32'd0);
        chk("reset_stall", 32'(o_stall), 32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_in_ready", 32'(o_in_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].sel != sel) begin
                idle(3);
                sel = vecs[i].sel;
            end
            send(vecs[i].instr, vecs[i].cls);
        end
        idle(3);
        sel = 1'b0;
        idle(2);

        send(32'h002081B3, 12'h001);
        chk("latency_valid", 32'(o_out_valid), 32'd1);
        chk("latency_class", 32'(o_class), 32'h001);
        chk("latency_rd", 32'(o_rd), 32'd3);
        chk("latency_rs1", 32'(o_rs1), 32'd1);
        chk("latency_rs2", 32'(o_rs2), 32'd2);
        idle(2);

        out_cyc.delete();
        send(32'h0000A283, 12'h004);
        present(32'h00128333, 12'h001);
        @(negedge clk);
        chk("a_hazard_stall", 32'(o_stall), 32'd1);
        chk("a_hazard_in_ready", 32'(o_in_ready), 32'd0);
        send(32'h00128333, 12'h001);
        idle(3);
        chk("a_stall_count", 32'(out_cyc.size()), 32'd2);
        if (out_cyc.size() == 2) chk("a_stall_spacing", 32'(out_cyc[1] - out_cyc[0]), 32'd2);

        out_cyc.delete();
        send(32'h0000A003, 12'h004);
        send(32'h00128333, 12'h001);
        idle(3);
        chk("x0_count", 32'(out_cyc.size()), 32'd2);
        if (out_cyc.size() == 2) chk("x0_spacing", 32'(out_cyc[1] - out_cyc[0]), 32'd1);

        out_ready = 1'b0;
        send(32'h0000A283, 12'h004);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(o_out_valid), 32'd1);
            chk("hold_instr", o_instr, 32'h0000A283);
            chk("hold_in_ready", 32'(o_in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_valid", 32'(o_out_valid), 32'd0);
        idle(2);

        sel = 1'b1;
        idle(2);
        out_cyc.delete();
        send(32'h0000A283, 12'h004);
        send(32'h00128333, 12'h001);
        idle(3);
        chk("b_stall_count", 32'(out_cyc.size()), 32'd2);
        if (out_cyc.size() == 2) chk("b_stall_spacing", 32'(out_cyc[1] - out_cyc[0]), 32'd4);

        out_cyc.delete();
        send(32'h0000A283, 12'h004);
        present(32'h00128333, 12'h001);
        @(posedge clk); #1;
        chk("flush_pre_stall", 32'(o_stall), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(o_in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_out_valid", 32'(o_out_valid), 32'd0);
        chk("flush_stall", 32'(o_stall), 32'd0);
        send(32'h00128333, 12'h001);
        idle(3);
        chk("flush_count", 32'(out_cyc.size()), 32'd2);
        if (out_cyc.size() == 2) chk("flush_spacing", 32'(out_cyc[1] - out_cyc[0]), 32'd3);

        send(32'h0000A283, 12'h004);
        present(32'h00128333, 12'h001);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(o_out_valid), 32'd0);
        chk("arst_class", 32'(o_class), 32'd0);
        chk("arst_instr", o_instr, 32'd0);
        chk("arst_fields", {17'd0, o_rd, o_rs1, o_rs2}, 32'd0);
        chk("arst_funct3", 32'(o_f3), 32'd0);
        chk("arst_stall", 32'(o_stall), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_in_ready", 32'(o_in_ready), 32'd1);
        chk("arst_idle_valid", 32'(o_out_valid), 32'd0);

        idle(2);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_type_decoder.md
Name: pipelined_type_decoder

Overview:
Registered, parametrised successor to the combinational opcode-class decoder. Sits between fetch and execute as one pipeline stage. It classifies each RV32I instruction into a one-hot class vector and extracts the register fields. It detects load-use hazards against the previously accepted instruction, inserts a configurable number of bubble cycles, and honours valid/ready backpressure and flush.

Parameters:
INSTR_W, 32, instruction width; must be >= 32; only bits [31:0] are decoded, the full word is passed through.
STALL_CYCLES, 1, bubbles inserted on a load-use hazard; legal range 1..7.
EN_SYSTEM, 1, 1 = decode FENCE (0001111) and SYSTEM (1110011) as classes; 0 = flag them illegal.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
flush  input  1  synchronous pipeline flush.
in_valid  input  1  upstream instruction valid.
in_ready  output  1  stage can accept an instruction this cycle.
instr_i  input  INSTR_W  instruction word.
out_valid  output  1  decoded result valid.
out_ready  input  1  downstream accepts the result.
instr_o  output  INSTR_W  registered copy of the accepted instruction.
class_o  output  12  one-hot class, bit order [0]r_type [1]i_type [2]load [3]store [4]branch [5]jal [6]jalr [7]lui [8]auipc [9]fence [10]system [11]illegal.
rd_o, rs1_o, rs2_o  output  5 each  instr[11:7], [19:15], [24:20].
funct3_o  output  3  instr[14:12].
stall_o  output  1  hazard stall active.

Behaviour:
- Reset (async, rst=1): out_valid=0, class_o=0, instr_o=0, rd_o/rs1_o/rs2_o/funct3_o=0, stall_o=0, FSM=RUN, stall counter=0, last_load=0, last_rd=0. Reset mid-stall abandons the stall immediately.
- Classification is combinational on instr_i[6:0] and registered on accept. Exactly one class_o bit is set.
- illegal is set when instr_i[1:0]!=2'b11, when the opcode is unmatched, or when the opcode is FENCE/SYSTEM and EN_SYSTEM=0.
- Register-use rules:
  - r_type, store, branch use rs1 and rs2.
  - i_type, load, jalr use rs1.
  - All other classes use neither.
- hazard (combinational) = in_valid & last_load & (last_rd!=0) & ((uses_rs1 & rs1==last_rd) | (uses_rs2 & rs2==last_rd)).
- in_ready = (state==RUN) & !hazard & (!out_valid | out_ready).
- Accept (in_valid & in_ready):
  - Output registers load next cycle and out_valid=1. Latency is exactly 1 cycle.
  - last_load <= class is load; last_rd <= rd.
- Hold: while out_valid & !out_ready, all outputs stay stable.
- Drain: out_valid clears on out_ready when no new accept occurs in the same cycle.
- FSM RUN -> STALL: when state==RUN & hazard & (!out_valid | out_ready).
  - Counter <= STALL_CYCLES.
  - out_valid goes 0 (bubble).
- FSM in STALL:
  - stall_o=1 and in_ready=0.
  - Counter decrements each cycle.
  - When the counter reaches 1: next state RUN and last_load <= 0. The held instruction is accepted on the following cycle.
- Bubbles: exactly STALL_CYCLES cycles with out_valid=0 appear between the load and the dependent instruction.
- stall_o = (state==STALL) | hazard.
- Load to x0 never stalls.
- Only the immediately preceding accepted instruction is tracked.
- flush (synchronous, highest priority after rst):
  - out_valid=0, FSM=RUN, counter=0, last_load=0.
  - An input presented in the same cycle is not accepted (in_ready forced 0).
- Simultaneous accept and drain in the same cycle: the new result replaces the old; out_valid stays 1.

Test Plan:
- Reset with rst asserted mid-stream -> all outputs 0 asynchronously; in_ready=1 after release with out_valid=0.
- Accept 0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle out_valid=1, class_o=12'h001, rd_o=3, rs1_o=1, rs2_o=2.
- Accept 0x0000A283 (lw x5,0(x1)), then present 0x00128333 (add x6,x5,x1), STALL_CYCLES=1 -> hazard, stall_o=1; one out_valid=0 bubble; add emerges 2 cycles after lw with class_o=12'h001. Repeat with STALL_CYCLES=3 -> 3 bubbles.
- 0x0000A003 (lw x0) followed by 0x00128333 -> no stall; back-to-back out_valid.
- out_ready=0 for 4 cycles with 0x0000A283 in the output -> outputs stable, in_ready=0; then out_ready=1 -> drains.
- 0x00000073 (ecall) with EN_SYSTEM=1 -> class_o=12'h400; with EN_SYSTEM=0 -> 12'h800. Opcode 0x7F -> 12'h800.
- flush during STALL -> out_valid=0, stall_o=0, FSM RUN next cycle; the dependent add is accepted without further bubbles.
